// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - BTB entry type, history counter helpers and lane indices
package bp_pkg;

  localparam int LANE1   = 0;
  localparam int LANE2   = 1;
  localparam int BH_MAXW = 8;  // widest supported history counter (B_H <= 8)

  localparam logic [BH_MAXW-1:0] BH_ONE = BH_MAXW'(1);

  typedef struct packed {
    logic               valid;
    logic [63:0]        bia;
    logic [63:0]        bta;
    logic [BH_MAXW-1:0] bh;
  } btb_entry_t;

  function automatic logic [BH_MAXW-1:0] bh_sat_inc(input logic [BH_MAXW-1:0] bh,
                                                    input logic [BH_MAXW-1:0] cmax);
    return (bh >= cmax) ? cmax : bh + BH_ONE;
  endfunction

  function automatic logic [BH_MAXW-1:0] bh_dec(input logic [BH_MAXW-1:0] bh);
    return (bh == '0) ? '0 : bh - BH_ONE;
  endfunction

  // Training of an entry that already matches the branch address.
  function automatic btb_entry_t bp_apply_hit(input btb_entry_t e, input logic taken,
                                              input logic [63:0] target,
                                              input logic [BH_MAXW-1:0] cmax);
    btb_entry_t r;
    r = e;
    if (taken) begin
      if (e.bta == target) begin
        r.bh = bh_sat_inc(e.bh, cmax);
      end else begin
        r.bta = target;
        r.bh  = BH_ONE;
      end
    end else begin
      r.bh    = bh_dec(e.bh);
      r.valid = (r.bh != '0);
    end
    return r;
  endfunction

  function automatic btb_entry_t bp_new_entry(input logic [63:0] pc, input logic [63:0] target);
    btb_entry_t r;
    r.valid = 1'b1;
    r.bia   = pc;
    r.bta   = target;
    r.bh    = BH_ONE;
    return r;
  endfunction

endpackage

// File: rtl/btb_alloc.sv
// rtl/btb_alloc.sv - picks two distinct allocation slots: free entries first, then victims
module btb_alloc #(
  parameter int B_N = 16,
  parameter int PW  = 4
) (
  input  logic [B_N-1:0] valid,
  input  logic [PW-1:0]  vptr,
  input  logic [1:0]     nreq,
  output logic [PW-1:0]  first_idx,
  output logic [PW-1:0]  second_idx,
  output logic [1:0]     evict_cnt
);

  logic          found0, found1;
  logic [PW-1:0] i0, i1, vnext;

  always_comb begin
    found0 = 1'b0;
    found1 = 1'b0;
    i0     = '0;
    i1     = '0;
    for (int i = 0; i < B_N; i++) begin
      if (!valid[i]) begin
        if (!found0) begin
          found0 = 1'b1;
          i0     = PW'(i);
        end else if (!found1) begin
          found1 = 1'b1;
          i1     = PW'(i);
        end
      end
    end

    vnext = (vptr == PW'(B_N - 1)) ? '0 : vptr + PW'(1);

    first_idx  = found0 ? i0 : vptr;
    // With one free entry the second request takes the current victim, not the next one.
    second_idx = found1 ? i1 : (found0 ? vptr : vnext);

    case (nreq)
      2'd1:    evict_cnt = found0 ? 2'd0 : 2'd1;
      2'd2:    evict_cnt = found1 ? 2'd0 : (found0 ? 2'd1 : 2'd2);
      default: evict_cnt = 2'd0;
    endcase
  end

endmodule

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - fully-associative BTB: dual-slot registered lookup, dual-lane training
module btb_predictor
  import bp_pkg::*;
#(
  parameter int B_N = 16,
  parameter int B_H = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallF,
  input  logic        FlushF,
  input  logic [63:0] PCNextF,
  output logic        PredValidF,
  output logic        PredTaken1F,
  output logic        PredTaken2F,
  output logic [63:0] PredTarget1F,
  output logic [63:0] PredTarget2F,
  output logic [63:0] PredNextPCF,
  input  logic        UpdValidE1,
  input  logic        UpdValidE2,
  input  logic        UpdTakenE1,
  input  logic        UpdTakenE2,
  input  logic [63:0] UpdPCE1,
  input  logic [63:0] UpdPCE2,
  input  logic [63:0] UpdTargetE1,
  input  logic [63:0] UpdTargetE2
);

  localparam int PW = (B_N > 1) ? $clog2(B_N) : 1;
  localparam logic [BH_MAXW-1:0] CMAX = BH_MAXW'((1 << B_H) - 1);

  btb_entry_t     tbl   [B_N];
  btb_entry_t     tbl_n [B_N];
  logic [PW-1:0]  vptr, vptr_n;
  logic [B_N-1:0] valid_vec, hit1, hit2;
  logic [63:0]    pc2, tgt1, tgt2;

  logic [63:0]    upd_pc     [2];
  logic [63:0]    upd_tgt    [2];
  logic           upd_taken  [2];
  logic           lane_en    [2];
  logic           lane_alloc [2];
  logic [B_N-1:0] lane_match [2];
  logic [PW-1:0]  lane_idx   [2];
  logic [1:0]     nreq, evict_cnt;
  logic [PW-1:0]  first_idx, second_idx;

  // Read CAMs for both fetch slots and update CAMs for both execute lanes.
  always_comb begin
    pc2       = PCNextF + 64'd4;
    tgt1      = '0;
    tgt2      = '0;
    hit1      = '0;
    hit2      = '0;
    valid_vec = '0;

    upd_pc[LANE1]    = UpdPCE1;
    upd_pc[LANE2]    = UpdPCE2;
    upd_tgt[LANE1]   = UpdTargetE1;
    upd_tgt[LANE2]   = UpdTargetE2;
    upd_taken[LANE1] = UpdTakenE1;
    upd_taken[LANE2] = UpdTakenE2;
    // Lane 2 is younger, so it alone trains when both lanes resolve the same branch.
    lane_en[LANE1]   = UpdValidE1 && !(UpdValidE2 && (UpdPCE1 == UpdPCE2));
    lane_en[LANE2]   = UpdValidE2;
    lane_match[LANE1] = '0;
    lane_match[LANE2] = '0;

    for (int i = 0; i < B_N; i++) begin
      valid_vec[i] = tbl[i].valid;
      hit1[i]      = tbl[i].valid && (tbl[i].bia == PCNextF);
      hit2[i]      = tbl[i].valid && (tbl[i].bia == pc2);
      if (hit1[i]) tgt1 = tgt1 | tbl[i].bta;
      if (hit2[i]) tgt2 = tgt2 | tbl[i].bta;
      for (int l = 0; l < 2; l++) begin
        lane_match[l][i] = tbl[i].valid && (tbl[i].bia == upd_pc[l]);
      end
    end

    for (int l = 0; l < 2; l++) begin
      lane_alloc[l] = lane_en[l] && upd_taken[l] && !(|lane_match[l]);
    end
    nreq = 2'(lane_alloc[LANE1]) + 2'(lane_alloc[LANE2]);
  end

  btb_alloc #(
    .B_N (B_N),
    .PW  (PW)
  ) u_alloc (
    .valid      (valid_vec),
    .vptr       (vptr),
    .nreq       (nreq),
    .first_idx  (first_idx),
    .second_idx (second_idx),
    .evict_cnt  (evict_cnt)
  );

  always_comb begin
    lane_idx[LANE1] = first_idx;
    lane_idx[LANE2] = lane_alloc[LANE1] ? second_idx : first_idx;
    for (int i = 0; i < B_N; i++) begin
      tbl_n[i] = tbl[i];
    end
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < B_N; i++) begin
        if (lane_en[l] && lane_match[l][i]) begin
          tbl_n[i] = bp_apply_hit(tbl_n[i], upd_taken[l], upd_tgt[l], CMAX);
        end
        if (lane_alloc[l] && (lane_idx[l] == PW'(i))) begin
          tbl_n[i] = bp_new_entry(upd_pc[l], upd_tgt[l]);
        end
      end
    end
    vptr_n = PW'((int'(vptr) + int'(evict_cnt)) % B_N);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < B_N; i++) begin
        tbl[i] <= '0;
      end
      vptr         <= '0;
      PredValidF   <= 1'b0;
      PredTaken1F  <= 1'b0;
      PredTaken2F  <= 1'b0;
      PredTarget1F <= '0;
      PredTarget2F <= '0;
      PredNextPCF  <= '0;
    end else begin
      for (int i = 0; i < B_N; i++) begin
        tbl[i] <= tbl_n[i];
      end
      vptr <= vptr_n;
      if (FlushF) begin
        PredValidF   <= 1'b0;
        PredTaken1F  <= 1'b0;
        PredTaken2F  <= 1'b0;
        PredTarget1F <= '0;
        PredTarget2F <= '0;
        PredNextPCF  <= '0;
      end else if (!StallF) begin
        PredValidF   <= 1'b1;
        PredTaken1F  <= |hit1;
        PredTaken2F  <= |hit2;
        PredTarget1F <= tgt1;
        PredTarget2F <= tgt2;
        PredNextPCF  <= (|hit1) ? tgt1 : ((|hit2) ? tgt2 : PCNextF + 64'd8);
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - scoreboard bench for btb_predictor against a sequential table model
module tb_btb_predictor;

  localparam int N    = 16;
  localparam int CMAX = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        StallF = 1'b0, FlushF = 1'b0;
  logic [63:0] PCNextF = '0;
  logic        PredValidF, PredTaken1F, PredTaken2F;
  logic [63:0] PredTarget1F, PredTarget2F, PredNextPCF;
  logic        UpdValidE1 = 1'b0, UpdValidE2 = 1'b0, UpdTakenE1 = 1'b0, UpdTakenE2 = 1'b0;
  logic [63:0] UpdPCE1 = '0, UpdPCE2 = '0, UpdTargetE1 = '0, UpdTargetE2 = '0;

  btb_predictor #(.B_N(N), .B_H(2)) dut (
    .clk(clk), .reset_n(reset_n), .StallF(StallF), .FlushF(FlushF), .PCNextF(PCNextF),
    .PredValidF(PredValidF), .PredTaken1F(PredTaken1F), .PredTaken2F(PredTaken2F),
    .PredTarget1F(PredTarget1F), .PredTarget2F(PredTarget2F), .PredNextPCF(PredNextPCF),
    .UpdValidE1(UpdValidE1), .UpdValidE2(UpdValidE2), .UpdTakenE1(UpdTakenE1),
    .UpdTakenE2(UpdTakenE2), .UpdPCE1(UpdPCE1), .UpdPCE2(UpdPCE2),
    .UpdTargetE1(UpdTargetE1), .UpdTargetE2(UpdTargetE2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v, t1, t2;
    logic [63:0] tg1, tg2, npc;
  } exp_t;

  exp_t sb[$];
  exp_t prev_exp;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  // Reference table: plain arrays, updates applied one lane at a time in program order.
  bit          mv   [N];
  logic [63:0] mbia [N];
  logic [63:0] mbta [N];
  int          mbh  [N];
  int          mptr;

  function automatic int mfind(input logic [63:0] pc);
    for (int i = 0; i < N; i++) if (mv[i] && mbia[i] == pc) return i;
    return -1;
  endfunction

  function automatic exp_t mlook(input logic [63:0] pc);
    exp_t e;
    int h1, h2;
    h1 = mfind(pc);
    h2 = mfind(pc + 64'd4);
    e.v   = 1'b1;
    e.t1  = (h1 >= 0);
    e.t2  = (h2 >= 0);
    e.tg1 = (h1 >= 0) ? mbta[h1] : 64'd0;
    e.tg2 = (h2 >= 0) ? mbta[h2] : 64'd0;
    e.npc = e.t1 ? e.tg1 : (e.t2 ? e.tg2 : pc + 64'd8);
    return e;
  endfunction

  task automatic mupd(input logic [63:0] pc, input bit taken, input logic [63:0] tg);
    int h, slot;
    h = mfind(pc);
    if (taken) begin
      if (h >= 0) begin
        if (mbta[h] == tg) mbh[h] = (mbh[h] + 1 > CMAX) ? CMAX : mbh[h] + 1;
        else begin mbta[h] = tg; mbh[h] = 1; end
      end else begin
        slot = -1;
        for (int i = 0; i < N; i++) if (!mv[i] && slot < 0) slot = i;
        if (slot < 0) begin slot = mptr; mptr = (mptr + 1) % N; end
        mv[slot] = 1; mbia[slot] = pc; mbta[slot] = tg; mbh[slot] = 1;
      end
    end else if (h >= 0) begin
      mbh[h] = mbh[h] - 1;
      if (mbh[h] == 0) mv[h] = 0;
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < N; i++) begin mv[i] = 0; mbia[i] = '0; mbta[i] = '0; mbh[i] = 0; end
    mptr = 0;
    prev_exp = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // One clock of stimulus: predict the registered outputs, train the model, then hand off.
  task automatic tick();
    exp_t e;
    if (FlushF) e = '0;
    else if (StallF) e = prev_exp;
    else e = mlook(PCNextF);
    if (UpdValidE1 && !(UpdValidE2 && UpdPCE1 == UpdPCE2)) mupd(UpdPCE1, UpdTakenE1, UpdTargetE1);
    if (UpdValidE2) mupd(UpdPCE2, UpdTakenE2, UpdTargetE2);
    prev_exp = e;
    @(posedge clk);
    #1;
    sb.push_back(e);
    UpdValidE1 = 0; UpdValidE2 = 0; StallF = 0; FlushF = 0;
  endtask

  task automatic upd1(input bit t, input logic [63:0] pc, input logic [63:0] tg);
    UpdValidE1 = 1; UpdTakenE1 = t; UpdPCE1 = pc; UpdTargetE1 = tg;
  endtask

  task automatic upd2(input bit t, input logic [63:0] pc, input logic [63:0] tg);
    UpdValidE2 = 1; UpdTakenE2 = t; UpdPCE2 = pc; UpdTargetE2 = tg;
  endtask

  task automatic look(input logic [63:0] pc);
    PCNextF = pc;
    tick();
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      exp_t a;
      e = sb.pop_front();
      a = {PredValidF, PredTaken1F, PredTaken2F, PredTarget1F, PredTarget2F, PredNextPCF};
      total_cnt++;
      if (a === e) pass_cnt++;
      else $display("FAIL lookup: got v=%b t=%b%b tg1=%h tg2=%h npc=%h expected v=%b t=%b%b tg1=%h tg2=%h npc=%h",
                    a.v, a.t1, a.t2, a.tg1, a.tg2, a.npc, e.v, e.t1, e.t2, e.tg1, e.tg2, e.npc);
    end
  end

  logic [63:0] pool  [12];
  logic [63:0] tpool [3];

  initial begin
    mreset();
    #3;
    chk("reset_valid", {63'd0, PredValidF}, 64'd0);
    chk("reset_npc", PredNextPCF, 64'd0);
    @(negedge clk);
    reset_n = 1;
    #1;

    look(64'h1000);
    chk("first_npc", PredNextPCF, 64'h1008);

    upd1(1, 64'h1004, 64'h2000);
    look(64'h1000);
    chk("no_bypass_taken2", {63'd0, PredTaken2F}, 64'd0);
    look(64'h1000);
    chk("trained_npc", PredNextPCF, 64'h2000);

    repeat (4) begin upd1(1, 64'h1004, 64'h2000); look(64'h1000); end
    repeat (2) begin upd2(0, 64'h1004, 64'h0); look(64'h1000); end
    chk("still_hit_after_two_nt", {63'd0, PredTaken2F}, 64'd1);
    upd2(0, 64'h1004, 64'h0);
    look(64'h1000);
    look(64'h1000);
    chk("invalid_after_three_nt", {63'd0, PredTaken2F}, 64'd0);

    upd1(1, 64'h5000, 64'h3000);
    upd2(1, 64'h5000, 64'h4000);
    look(64'h5000);
    look(64'h5000);
    chk("same_pc_lane2_wins", PredTarget1F, 64'h4000);

    StallF = 1; look(64'h9999_0000);
    StallF = 1; look(64'h7777_0000);
    chk("stall_hold", PredNextPCF, 64'h4000);
    FlushF = 1; look(64'h5000);
    chk("flush_npc", PredNextPCF, 64'd0);
    look(64'h5000);

    #1;
    reset_n = 0;
    #1;
    chk("async_valid", {63'd0, PredValidF}, 64'd0);
    chk("async_target", PredTarget1F, 64'd0);
    mreset();
    sb.delete();
    sb.push_back('0);
    #1;
    reset_n = 1;
    look(64'h5000);
    chk("async_table_cleared", {63'd0, PredTaken1F}, 64'd0);

    for (int k = 0; k < 8; k++) begin
      upd1(1, 64'h10000 + 64'(2 * k) * 64'h100, 64'h10040 + 64'(2 * k) * 64'h100);
      upd2(1, 64'h10000 + 64'(2 * k + 1) * 64'h100, 64'h10040 + 64'(2 * k + 1) * 64'h100);
      look(64'h10000 + 64'(k) * 64'h100);
    end
    upd1(1, 64'h20000, 64'h20040);
    upd2(1, 64'h20100, 64'h20140);
    look(64'h10000);
    look(64'h10000);
    chk("evict_entry0", {63'd0, PredTaken1F}, 64'd0);
    look(64'h20000);
    look(64'h10200);
    for (int k = 0; k < 13; k++) begin
      upd1(1, 64'h30000 + 64'(k) * 64'h100, 64'h5);
      look(64'h10F00);
    end
    upd1(1, 64'h40000, 64'h40040);
    upd2(1, 64'h40100, 64'h40140);
    look(64'h10F00);
    look(64'h10F00);
    chk("wrap_entry15", {63'd0, PredTaken1F}, 64'd0);
    look(64'h20000);
    chk("wrap_entry0", {63'd0, PredTaken1F}, 64'd0);
    look(64'h40000);
    look(64'h20100);

    reset_n = 0;
    mreset();
    sb.delete();
    #1;
    reset_n = 1;

    for (int k = 0; k < 10; k++) pool[k] = 64'h4000 + 64'(k) * 64'd4;
    pool[10] = 64'hFFFF_FFFF_FFFF_FFFC;
    pool[11] = 64'd0;
    tpool[0] = 64'h8000; tpool[1] = 64'h8800; tpool[2] = 64'h0;
    for (int c = 0; c < 500; c++) begin
      StallF = ($urandom_range(0, 99) < 15);
      FlushF = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 60)
        upd1($urandom_range(0, 99) < 70, pool[$urandom_range(0, 11)], tpool[$urandom_range(0, 2)]);
      if ($urandom_range(0, 99) < 60)
        upd2($urandom_range(0, 99) < 70, pool[$urandom_range(0, 11)], tpool[$urandom_range(0, 2)]);
      look(pool[$urandom_range(0, 11)]);
    end

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
